// File: rtl/sm_hex_display_mux.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous loading, leading-zero
// blanking and 16-level PWM brightness. Optional anode dead time: SM_HEX_DISPLAY_MUX_DEADTIME_EN.
module sm_hex_display_mux #(
    parameter int unsigned DIGITS           = 4,
    parameter int unsigned CLK_DIV_W        = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_en,
    input  logic [3:0]            brightness,
    output logic [7:0]            seven_segments,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame_start
);

    localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = ANODE_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CLK_DIV_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  number_q, number_d;
    logic [DIGITS-1:0]    dp_q, dp_d;
    logic                 pending_q, pending_d;
    logic                 frame_start_q;
    logic [7:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    anode_q, anode_d;

    logic                 rollover;
    logic                 wrap;
    logic                 capture;
    logic [DIGITS-1:0]    blank_mask;
    logic                 zero_run;
    logic [3:0]           nib;
    logic                 digit_dp;
    logic                 digit_blank;
    logic [DIGITS-1:0]    anode_sel;
    logic [DIGITS-1:0]    anode_on;
    logic                 lit;
    logic [7:0]           seg_active;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Scan sequencing and frame-synchronous shadow capture
    always_comb begin
        rollover = (slot_q == '1);
        slot_d   = slot_q + 1'b1;
        idx_d    = idx_q;
        if (rollover) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        wrap      = rollover && (idx_d == '0);
        capture   = wrap && (load || pending_q);
        number_d  = capture ? number : number_q;
        dp_d      = capture ? dp : dp_q;
        pending_d = capture ? 1'b0 : (pending_q || load);
    end

    // Scanning from the most significant digit down builds the "all zero from here up" run
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            zero_run = zero_run && (number_q[4*(DIGITS-1-j) +: 4] == 4'h0);
            blank_mask[DIGITS-1-j] = zero_run && blank_en && ((DIGITS-1-j) != 0);
        end
    end

    always_comb begin
        nib         = 4'h0;
        digit_dp    = 1'b0;
        digit_blank = 1'b0;
        anode_sel   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib          = number_q[4*i +: 4];
                digit_dp     = dp_q[i];
                digit_blank  = blank_mask[i];
                anode_sel[i] = 1'b1;
            end
        end

        seg_active = {digit_dp, digit_blank ? 7'h00 : hex7(nib)};
        seg_d      = SEG_ACTIVE_LOW ? ~seg_active : seg_active;

        lit = (slot_q[CLK_DIV_W-1 -: 4] <= brightness);
`ifdef SM_HEX_DISPLAY_MUX_DEADTIME_EN
        lit = lit && (slot_q >= CLK_DIV_W'(4));
`else
        lit = lit && 1'b1;
`endif
        anode_on = lit ? anode_sel : '0;
        anode_d  = ANODE_ACTIVE_LOW ? ~anode_on : anode_on;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            slot_q        <= '0;
            idx_q         <= '0;
            number_q      <= '0;
            dp_q          <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            anode_q       <= AN_OFF;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            number_q      <= number_d;
            dp_q          <= dp_d;
            pending_q     <= pending_d;
            frame_start_q <= wrap;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
        end
    end

    assign seven_segments = seg_q;
    assign anodes         = anode_q;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Directed bench for sm_hex_display_mux (DIGITS=4, CLK_DIV_W=6, active-low anodes and segments).
module tb_sm_hex_display_mux;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] number = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        blank_en = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [7:0]  seven_segments;
    logic [3:0]  anodes;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dpv;
        logic        blank;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[$];

    sm_hex_display_mux #(
        .DIGITS(4),
        .CLK_DIV_W(6),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .number(number),
        .dp(dp),
        .load(load),
        .blank_en(blank_en),
        .brightness(brightness),
        .seven_segments(seven_segments),
        .anodes(anodes),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_start && n < 600);
        check({name, " frame_start seen"}, {31'b0, frame_start}, 32'd1);
    endtask

    task automatic read_digit(input int unsigned d, output logic [7:0] seg);
        logic [3:0] want;
        bit found;
        want  = 4'b0001 << d;
        want  = ~want;
        found = 1'b0;
        seg   = 8'h00;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clock);
            if (anodes == want) begin
                seg   = seven_segments;
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL read_digit%0d: anode %0h never active", d, want);
        end
    endtask

    task automatic load_and_settle(input logic [15:0] num, input logic [3:0] d, input logic b);
        @(negedge clock);
        number   = num;
        dp       = d;
        blank_en = b;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_frame("load");
        @(negedge clock);
    endtask

    task automatic scan_frame(input logic [3:0] br, input int unsigned exp_active);
        int unsigned active, bad, fs_at, fs_cnt;
        logic [3:0] scan_exp [4];
        scan_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        active = 0; bad = 0; fs_at = 0; fs_cnt = 0;
        brightness = br;
        wait_frame($sformatf("scan br%0d", br));
        for (int unsigned t = 0; t < 256; t++) begin
            @(negedge clock);
            if (anodes != 4'hF) active++;
            if (!(anodes inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) bad++;
            if (frame_start) begin
                fs_cnt++;
                fs_at = t;
            end
            if (br == 4'hF && (t % 64) == 32)
                check($sformatf("scan order slot%0d", t / 64), {28'b0, anodes}, {28'b0, scan_exp[t / 64]});
        end
        check($sformatf("active clocks br%0d", br), active, exp_active);
        check($sformatf("onehot br%0d", br), bad, 0);
        check($sformatf("frame_start count br%0d", br), fs_cnt, 1);
        check($sformatf("frame_start period br%0d", br), fs_at, 255);
    endtask

    initial begin
        logic [7:0] seg;
        int unsigned torn;
        int n;

        vecs.push_back('{16'h12AF, 4'b0100, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}});
        vecs.push_back('{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}});
        vecs.push_back('{16'h0050, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'h92, 8'hC0}});
        vecs.push_back('{16'h3456, 4'b0000, 1'b0, {8'hB0, 8'h99, 8'h92, 8'h82}});
        vecs.push_back('{16'h789B, 4'b1111, 1'b0, {8'h78, 8'h00, 8'h10, 8'h03}});
        vecs.push_back('{16'h0CDE, 4'b0000, 1'b1, {8'hFF, 8'hC6, 8'hA1, 8'h86}});
        vecs.push_back('{16'h0000, 4'b0001, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h40}});
        vecs.push_back('{16'h1000, 4'b0000, 1'b1, {8'hF9, 8'hC0, 8'hC0, 8'hC0}});
        vecs.push_back('{16'h0102, 4'b0000, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'hA4}});
        vecs.push_back('{16'h0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}});

        // Reset and idle
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset anodes", {28'b0, anodes}, 32'hF);
        check("reset segments", {24'b0, seven_segments}, 32'hFF);
        check("reset frame_start", {31'b0, frame_start}, 32'd0);
        resetn = 1'b1;
        read_digit(0, seg);
        check("idle digit0", {24'b0, seg}, 32'hC0);
        read_digit(3, seg);
        check("idle digit3", {24'b0, seg}, 32'hC0);

        // Scan order, frame period and brightness gating
`ifdef SM_HEX_DISPLAY_MUX_DEADTIME_EN
        scan_frame(4'hF, 240);
        scan_frame(4'h7, 112);
        scan_frame(4'h0, 0);
`else
        scan_frame(4'hF, 256);
        scan_frame(4'h7, 128);
        scan_frame(4'h0, 16);
`endif
        brightness = 4'hF;

        // Load mid-frame: display must not change until the frame boundary
        wait_frame("sync");
        repeat (100) @(negedge clock);
        number = 16'h12AF;
        dp     = 4'b0100;
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        torn = 0;
        n    = 0;
        while (!frame_start && n < 400) begin
            if (seven_segments != 8'hC0) torn++;
            @(negedge clock);
            n++;
        end
        check("load frame_start", {31'b0, frame_start}, 32'd1);
        check("no tear before frame", torn, 0);
        @(negedge clock);
        read_digit(0, seg); check("sync digit0", {24'b0, seg}, 32'h8E);
        read_digit(1, seg); check("sync digit1", {24'b0, seg}, 32'h88);
        read_digit(2, seg); check("sync digit2", {24'b0, seg}, 32'h24);
        read_digit(3, seg); check("sync digit3", {24'b0, seg}, 32'hF9);

        // Inputs are sampled on the rollover clock, not on the load clock
        dp = 4'b0000;
        @(negedge clock);
        number = 16'h1111;
        load   = 1'b1;
        @(negedge clock);
        load   = 1'b0;
        number = 16'h2222;
        wait_frame("late sample");
        @(negedge clock);
        read_digit(0, seg); check("rollover sample digit0", {24'b0, seg}, 32'hA4);

        // Repeated loads merge into one capture; pending then clears
        @(negedge clock);
        number = 16'h3333;
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (5) @(negedge clock);
        number = 16'h4444;
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_frame("merge");
        @(negedge clock);
        number = 16'h5555;
        read_digit(0, seg); check("merged digit0", {24'b0, seg}, 32'h99);
        wait_frame("merge hold");
        @(negedge clock);
        read_digit(0, seg); check("no second capture", {24'b0, seg}, 32'h99);

        // Load on the rollover clock itself captures immediately
        wait_frame("edge sync");
        repeat (255) @(negedge clock);
        number = 16'h6666;
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        check("edge load frame_start", {31'b0, frame_start}, 32'd1);
        number = 16'h7777;
        @(negedge clock);
        read_digit(0, seg); check("edge load digit0", {24'b0, seg}, 32'h82);
        wait_frame("edge hold");
        @(negedge clock);
        read_digit(0, seg); check("edge load cleared", {24'b0, seg}, 32'h82);

        // Reset mid-operation with a pending load
        blank_en = 1'b0;
        number   = 16'h8888;
        read_digit(2, seg);
        load = 1'b1;
        @(negedge clock);
        load   = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        check("midreset anodes", {28'b0, anodes}, 32'hF);
        check("midreset segments", {24'b0, seven_segments}, 32'hFF);
        check("midreset frame_start", {31'b0, frame_start}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        wait_frame("after reset");
        @(negedge clock);
        read_digit(0, seg); check("pending discarded digit0", {24'b0, seg}, 32'hC0);
        read_digit(3, seg); check("pending discarded digit3", {24'b0, seg}, 32'hC0);

        // Decode / blanking / dp vectors
        foreach (vecs[v]) begin
            load_and_settle(vecs[v].num, vecs[v].dpv, vecs[v].blank);
            for (int unsigned d = 0; d < 4; d++) begin
                read_digit(d, seg);
                check($sformatf("vec%0d digit%0d", v, d), {24'b0, seg}, {24'b0, vecs[v].segs[8*d +: 8]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
